mux_sel_scanner: RTL

//  Drives the 2-bit select (a = LSB, b = MSB) of the downstream 4:1 gate-level
//  mux and samples its output Q. Steps through the enabled channels in order
//  0..3, waits SETTLE_CYC cycles after each select change, then captures Q.

---
 rtl/mux_sel_scanner_if.sv | 25 ++
 rtl/mux_sel_scanner.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mux_sel_scanner_if.sv
// Control, mux-select and frame-handshake bundle of the mux select scanner.
// The slave modport is the scanner side; the master modport is its environment.
interface mux_sel_scanner_if;
   logic       start;
   logic       cont;
   logic       stop;
   logic [3:0] ch_en;
   logic       sel_a;
   logic       sel_b;
   logic       mux_q;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_word;
   logic       busy;

   modport slave (
      input  start, cont, stop, ch_en, mux_q, out_ready,
      output sel_a, sel_b, out_valid, out_word, busy
   );

   modport master (
      output start, cont, stop, ch_en, mux_q, out_ready,
      input  sel_a, sel_b, out_valid, out_word, busy
   );
endinterface

// File: rtl/mux_sel_scanner.sv
// Steps a 4:1 mux select through the enabled channels, samples Q after a settle
// delay, and presents the assembled 4-bit frame over a valid/ready handshake.
module mux_sel_scanner #(
   parameter int SETTLE_CYC = 1,
   parameter int CNT_W      = 4
) (
   input logic               clk,
   input logic               rst_n,
   mux_sel_scanner_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      SAMPLE  = 2'd2,
      PRESENT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

   state_t           state_r;
   logic [1:0]       sel_r;
   logic [CNT_W-1:0] cnt_r;
   logic [3:0]       mask_r;
   logic             cont_r;
   logic             stop_pend_r;
   logic [3:0]       frame_r;
   logic             out_valid_r;
   logic [3:0]       out_word_r;
   logic             busy_r;

   logic [2:0]       start_ch_s;
   logic [2:0]       restart_ch_s;
   logic [2:0]       next_ch_s;
   logic [3:0]       sample_word_s;

   // Returns {found, index} of the lowest enabled channel at or above 'from'.
   function automatic logic [2:0] first_from(input logic [3:0] mask, input logic [2:0] from);
      logic [2:0] res;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (i >= int'(from) && mask[i]) begin
            res = {1'b1, 2'(i)};
         end
      end
      return res;
   endfunction

   assign start_ch_s    = first_from(bus.ch_en, 3'd0);
   assign restart_ch_s  = first_from(mask_r, 3'd0);
   assign next_ch_s     = first_from(mask_r, {1'b0, sel_r} + 3'd1);
   // Each channel is sampled once per frame, so its frame bit is still clear here.
   assign sample_word_s = frame_r | ({3'b000, bus.mux_q} << sel_r);

   assign bus.sel_a     = sel_r[0];
   assign bus.sel_b     = sel_r[1];
   assign bus.out_valid = out_valid_r;
   assign bus.out_word  = out_word_r;
   assign bus.busy      = busy_r;

   // Scan sequencer with registered select, frame and handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         sel_r       <= 2'b00;
         cnt_r       <= '0;
         mask_r      <= 4'b0000;
         cont_r      <= 1'b0;
         stop_pend_r <= 1'b0;
         frame_r     <= 4'b0000;
         out_valid_r <= 1'b0;
         out_word_r  <= 4'b0000;
         busy_r      <= 1'b0;
      end else begin
         if (state_r != IDLE && bus.stop) begin
            stop_pend_r <= 1'b1;
         end else begin
            stop_pend_r <= stop_pend_r;
         end

         case (state_r)
            IDLE: begin
               if (bus.start && bus.ch_en != 4'b0000) begin
                  mask_r  <= bus.ch_en;
                  cont_r  <= bus.cont;
                  frame_r <= 4'b0000;
                  sel_r   <= start_ch_s[1:0];
                  cnt_r   <= SETTLE_LD;
                  busy_r  <= 1'b1;
                  state_r <= SETTLE;
               end else begin
                  state_r <= IDLE;
               end
            end
            SETTLE: begin
               if (cnt_r == CNT_W'(1)) begin
                  state_r <= SAMPLE;
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            SAMPLE: begin
               frame_r <= sample_word_s;
               if (next_ch_s[2]) begin
                  sel_r   <= next_ch_s[1:0];
                  cnt_r   <= SETTLE_LD;
                  state_r <= SETTLE;
               end else begin
                  out_word_r  <= sample_word_s;
                  out_valid_r <= 1'b1;
                  state_r     <= PRESENT;
               end
            end
            PRESENT: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  // A stop arriving on the handshake edge itself still ends the scan.
                  if (cont_r && !stop_pend_r && !bus.stop) begin
                     frame_r <= 4'b0000;
                     sel_r   <= restart_ch_s[1:0];
                     cnt_r   <= SETTLE_LD;
                     state_r <= SETTLE;
                  end else begin
                     stop_pend_r <= 1'b0;
                     sel_r       <= 2'b00;
                     busy_r      <= 1'b0;
                     state_r     <= IDLE;
                  end
               end else begin
                  state_r <= PRESENT;
               end
            end
            default: begin
               state_r     <= IDLE;
               sel_r       <= 2'b00;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

endmodule
